// File: rtl/gpio_mmio.sv
// gpio_mmio: memory-mapped GPIO block with debounced switch inputs, sticky
// rising-edge flags (write-1-to-clear) and registered LED outputs.
// Register map: 0 SW (RO), 1 LED (RW), 2 EDGE (W1C), 3 CTRL.
// Optional feature: define GPIO_IRQ_EN to add the irq output and make
// register 3 an RW interrupt mask over the EDGE flags.
module gpio_mmio #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SW_W       = 10,
  parameter int unsigned LED_W      = 10,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  input  logic [SW_W-1:0]   switches,
`ifdef GPIO_IRQ_EN
  output logic [LED_W-1:0]  leds,
  output logic              irq
`else
  output logic [LED_W-1:0]  leds
`endif
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StAck} state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   rd_val;
  logic [LED_W-1:0]    led_q, led_d;
  logic [SW_W-1:0]     edge_q, edge_d;
  logic [SW_W-1:0]     sync1_q, sync2_q;
  logic [SW_W-1:0]     stable_q, stable_d;
  logic [SW_W-1:0]     rise;
  logic [CntW-1:0]     cnt_q [SW_W];
  logic [CntW-1:0]     cnt_d [SW_W];
  logic                accept;
  logic                wr_led, wr_edge;
  logic                unused_wdata;

  // Upper wdata bits beyond the register widths are intentionally ignored.
  assign unused_wdata = ^wdata;

  // A request is only taken in IDLE; sel during ACK is ignored.
  assign accept  = (state_q == StIdle) && sel;
  assign wr_led  = accept && we && (addr == 2'd1);
  assign wr_edge = accept && we && (addr == 2'd2);

  // Bus FSM next state: IDLE -> ACK on sel, ACK -> IDLE always.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sel) state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus FSM state and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [SW_W-1:0] mask_q, mask_d;
  logic            irq_q;
  logic            wr_mask;

  assign wr_mask = accept && we && (addr == 2'd3);

  // Mask register write.
  always_comb begin
    mask_d = mask_q;
    if (wr_mask) mask_d = wdata[SW_W-1:0];
  end

  // Mask and irq registers; irq lags EDGE/mask by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= |(edge_q & mask_q);
    end
  end

  assign irq = irq_q;
`endif

  // Read mux; unused upper bits read as zero.
  always_comb begin
    rd_val = '0;
    unique case (addr)
      2'd0: rd_val[SW_W-1:0]  = stable_q;
      2'd1: rd_val[LED_W-1:0] = led_q;
      2'd2: rd_val[SW_W-1:0]  = edge_q;
`ifdef GPIO_IRQ_EN
      2'd3: rd_val[SW_W-1:0]  = mask_q;
`else
      2'd3: rd_val = '0;
`endif
      default: rd_val = '0;
    endcase
  end

  // Read data is captured on the IDLE->ACK edge and is zero otherwise.
  always_comb begin
    ready_d = accept;
    rdata_d = (accept && !we) ? rd_val : '0;
  end

  // Per-channel debounce: count consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(SW_W); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  assign rise = stable_d & ~stable_q;

  // LED write and EDGE flags; a new rising edge wins over a clear.
  always_comb begin
    led_d  = led_q;
    edge_d = edge_q;
    if (wr_led)  led_d  = wdata[LED_W-1:0];
    if (wr_edge) edge_d = edge_q & ~wdata[SW_W-1:0];
    edge_d = edge_d | rise;
  end

  // Synchroniser, debounce and register state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      led_q    <= '0;
      edge_q   <= '0;
      for (int i = 0; i < int'(SW_W); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= switches;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      led_q    <= led_d;
      edge_q   <= edge_d;
      for (int i = 0; i < int'(SW_W); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign leds  = led_q;

endmodule

// File: doc/gpio_mmio.md
GPIO_MMIO -- requirements
Module: gpio_mmio

Interface
REQ-001 SHALL have parameter DATA_W, default 16, bus data width.
REQ-002 SHALL have parameter SW_W, default 10, switch channel count, 1..DATA_W.
REQ-003 SHALL have parameter LED_W, default 10, LED channel count, 1..DATA_W.
REQ-004 SHALL have parameter DEB_CYCLES, default 16, debounce stability cycles, >=1.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-007 SHALL have port sel  input  1  bus access request.
REQ-008 SHALL have port we  input  1  write when 1, read when 0.
REQ-009 SHALL have port addr  input  2  register index.
REQ-010 SHALL have port wdata  input  DATA_W  write data.
REQ-011 SHALL have port rdata  output  DATA_W  read data, valid while ready=1.
REQ-012 SHALL have port ready  output  1  one-cycle access-complete pulse.
REQ-013 SHALL have port switches  input  SW_W  raw asynchronous switch inputs.
REQ-014 SHALL have port leds  output  LED_W  registered LED drive.

Function
REQ-015 SHALL use a register map: 0 SW (RO, debounced state), 1 LED (RW), 2 EDGE (sticky rising-edge flags, write-1-to-clear), 3 CTRL (see REQ-028; RO zero otherwise).
REQ-016 SHALL read unused upper bits as 0 and ignore them on write; writes to RO registers SHALL have no effect.
REQ-017 SHALL implement bus FSM IDLE/ACK: IDLE with sel=1 -> ACK; ACK -> IDLE unconditionally.
REQ-018 SHALL assert ready only in ACK, for exactly one cycle, one cycle after sel is sampled in IDLE.
REQ-019 SHALL sample we/addr/wdata in IDLE; a write SHALL update its register on the IDLE->ACK edge.
REQ-020 SHALL present read data in rdata during ACK; rdata SHALL be 0 outside ACK.
REQ-021 SHALL ignore sel while in ACK; sel held high continuously yields ready every second cycle.
REQ-022 SHALL pass each switch through a 2-flop synchroniser before debouncing.
REQ-023 SHALL keep a per-channel counter: reset to 0 whenever synced equals stable; otherwise increment; at count DEB_CYCLES-1 with synced still different, stable takes synced and counter clears (change visible DEB_CYCLES cycles after first differing synced sample).
REQ-024 SHALL set EDGE[i] in the same cycle stable[i] transitions 0->1; 1->0 transitions SHALL NOT set flags.
REQ-025 SHALL give set priority over write-1-to-clear when both hit the same EDGE bit in one cycle.
REQ-026 SHALL drive leds directly from the LED register.

Reset
REQ-027 SHALL, on reset low, asynchronously clear FSM to IDLE, ready, rdata, leds, LED, EDGE, synchronisers, stable state, counters (and irq/mask) to 0; a transaction in progress SHALL be dropped without ready.

Configuration
REQ-028 SHALL, with macro GPIO_IRQ_EN defined, add output irq (1 bit, registered) and make register 3 an RW SW_W-bit IRQ mask; irq = OR(EDGE & mask), updated one cycle after EDGE/mask change.
REQ-029 SHALL, without GPIO_IRQ_EN, have no irq port and register 3 SHALL read 0 and ignore writes.

Verification (DATA_W=16, SW_W=10, LED_W=10, DEB_CYCLES=4)
REQ-030 Reset mid-ACK with write LED=0x3FF pending -> leds=0, ready stays 0, next read of addr 1 returns 0x0000.
REQ-031 Write addr 1 data 0xFFFF -> ready one cycle later, leds=0x3FF, read addr 1 returns 0x03FF.
REQ-032 switches 0x000->0x001 held -> SW reads 0x001 exactly 2+4 cycles after change; EDGE reads 0x001; glitch of 3 cycles -> SW stays 0x000.
REQ-033 Write addr 2 data 0x001 in same cycle as new rising edge on bit 0 -> EDGE bit 0 stays 1; later clear alone -> EDGE=0x000.
REQ-034 sel held high 6 cycles reading addr 0 -> exactly 3 ready pulses, alternating cycles.
REQ-035 With GPIO_IRQ_EN: mask=0x002, edge on bit 0 -> irq=0; edge on bit 1 -> irq=1 next cycle; W1C 0x002 -> irq=0.
